// File: rtl/step_pulse_gen_pkg.sv
// Shared types and width rules for the step/direction pulse generator.
package step_pulse_gen_pkg;

  localparam int DEFAULT_TIMER_W = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_EVAL      = 3'd1,
    S_DIR_SETUP = 3'd2,
    S_HIGH      = 3'd3,
    S_LOW       = 3'd4
  } state_t;

  // A signed delta needs one extra bit so 0 -> max is a jump, not a wrap.
  function automatic int delta_w(input int coord_w);
    return coord_w + 1;
  endfunction

endpackage

// File: rtl/step_pulse_gen_if.sv
// Point stream, timing controls, homing and step/dir outputs of step_pulse_gen.
interface step_pulse_gen_if #(
  parameter int P_X_COORD_W = 11,
  parameter int P_Y_COORD_W = 11,
  parameter int P_TIMER_W   = step_pulse_gen_pkg::DEFAULT_TIMER_W
);
  logic [P_X_COORD_W-1:0] i_x_val;
  logic [P_Y_COORD_W-1:0] i_y_val;
  logic                   i_vals_rdy;
  logic                   i_enable;
  logic [P_TIMER_W-1:0]   i_pulse_width;
  logic [P_TIMER_W-1:0]   i_step_period;
  logic                   i_home_load;
  logic [P_X_COORD_W-1:0] i_home_x;
  logic [P_Y_COORD_W-1:0] i_home_y;
  logic                   o_x_step;
  logic                   o_x_dir;
  logic                   o_y_step;
  logic                   o_y_dir;
  logic [P_X_COORD_W-1:0] o_pos_x;
  logic [P_Y_COORD_W-1:0] o_pos_y;
  logic                   o_room_for_line;
  logic                   o_busy;
  logic                   o_overflow;
  logic                   o_jump_err;

  modport slave (
    input  i_x_val, i_y_val, i_vals_rdy, i_enable, i_pulse_width, i_step_period,
           i_home_load, i_home_x, i_home_y,
    output o_x_step, o_x_dir, o_y_step, o_y_dir, o_pos_x, o_pos_y,
           o_room_for_line, o_busy, o_overflow, o_jump_err
  );

  modport master (
    output i_x_val, i_y_val, i_vals_rdy, i_enable, i_pulse_width, i_step_period,
           i_home_load, i_home_x, i_home_y,
    input  o_x_step, o_x_dir, o_y_step, o_y_dir, o_pos_x, o_pos_y,
           o_room_for_line, o_busy, o_overflow, o_jump_err
  );
endinterface

// File: rtl/step_pulse_gen_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_r;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full    = (count_r == (AW+1)'(DEPTH));
    empty   = (count_r == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = mem[rd_ptr];
    count   = count_r;
  end

  // Storage is left unreset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/step_pulse_gen.sv
// Buffers rasterised points and converts each unit move into step/dir pulses
// for two stepper axes with programmable pulse width and minimum step period.
module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int P_X_COORD_W       = 11,
  parameter int P_Y_COORD_W       = 11,
  parameter int P_FIFO_DEPTH_LOG2 = 12,
  parameter int P_MAX_LINE_PTS    = 2048,
  parameter int P_TIMER_W         = DEFAULT_TIMER_W
) (
  input logic            i_clk,
  input logic            i_reset,
  step_pulse_gen_if.slave bus
);
  localparam int DX_W  = delta_w(P_X_COORD_W);
  localparam int DY_W  = delta_w(P_Y_COORD_W);
  localparam int PT_W  = P_X_COORD_W + P_Y_COORD_W;
  localparam int DEPTH = 2 ** P_FIFO_DEPTH_LOG2;
  localparam int CNT_W = P_FIFO_DEPTH_LOG2 + 1;
  localparam int PER_W = P_TIMER_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LINE_C  = CNT_W'(P_MAX_LINE_PTS);
  localparam logic signed [DX_W-1:0] DX_ONE  = DX_W'(1);
  localparam logic signed [DX_W-1:0] DX_MONE = -DX_ONE;
  localparam logic signed [DY_W-1:0] DY_ONE  = DY_W'(1);
  localparam logic signed [DY_W-1:0] DY_MONE = -DY_ONE;

  state_t                  state_r;
  logic [P_X_COORD_W-1:0]  pt_x_r, pos_x_r;
  logic [P_Y_COORD_W-1:0]  pt_y_r, pos_y_r;
  logic                    x_dir_r, y_dir_r, x_step_r, y_step_r;
  logic                    mv_x_r, mv_y_r;
  logic [P_TIMER_W-1:0]    pw_r;
  logic [PER_W-1:0]        per_r, cnt_r;
  logic                    overflow_r, jump_err_r, room_r;

  logic [PT_W-1:0]         fifo_dout;
  logic                    fifo_full, fifo_empty, pop_s;
  logic [CNT_W-1:0]        fifo_count;
  logic signed [DX_W-1:0]  dx_s;
  logic signed [DY_W-1:0]  dy_s;
  logic                    jump_s, room_s;
  logic [P_TIMER_W-1:0]    pw_eff_s;
  logic [PER_W-1:0]        per_min_s, per_eff_s;

  sync_fifo #(
    .WIDTH (PT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (bus.i_vals_rdy),
    .din   ({bus.i_x_val, bus.i_y_val}),
    .pop   (pop_s),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    pop_s     = (state_r == S_IDLE) && bus.i_enable && !fifo_empty;
    dx_s      = $signed({1'b0, pt_x_r}) - $signed({1'b0, pos_x_r});
    dy_s      = $signed({1'b0, pt_y_r}) - $signed({1'b0, pos_y_r});
    jump_s    = (dx_s > DX_ONE) || (dx_s < DX_MONE) || (dy_s > DY_ONE) || (dy_s < DY_MONE);
    pw_eff_s  = (bus.i_pulse_width == '0) ? P_TIMER_W'(1) : bus.i_pulse_width;
    per_min_s = {1'b0, pw_eff_s} + PER_W'(1);
    per_eff_s = ({1'b0, bus.i_step_period} > per_min_s) ? {1'b0, bus.i_step_period} : per_min_s;
    room_s    = (DEPTH_C - fifo_count) >= LINE_C;
  end

  // cnt_r counts clocks since the step rise (1 in the first high cycle),
  // so a single counter covers both the pulse width and the period.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r    <= S_IDLE;
      pt_x_r     <= '0;
      pt_y_r     <= '0;
      pos_x_r    <= '0;
      pos_y_r    <= '0;
      x_dir_r    <= 1'b0;
      y_dir_r    <= 1'b0;
      x_step_r   <= 1'b0;
      y_step_r   <= 1'b0;
      mv_x_r     <= 1'b0;
      mv_y_r     <= 1'b0;
      pw_r       <= '0;
      per_r      <= '0;
      cnt_r      <= '0;
      overflow_r <= 1'b0;
      jump_err_r <= 1'b0;
      room_r     <= 1'b1;
    end else begin
      room_r <= room_s;
      if (bus.i_vals_rdy && fifo_full) overflow_r <= 1'b1;
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
            {pt_x_r, pt_y_r} <= fifo_dout;
            state_r          <= S_EVAL;
          end else if (bus.i_home_load && fifo_empty) begin
            pos_x_r <= bus.i_home_x;
            pos_y_r <= bus.i_home_y;
          end
        end
        S_EVAL: begin
          pw_r   <= pw_eff_s;
          per_r  <= per_eff_s;
          mv_x_r <= (dx_s != '0);
          mv_y_r <= (dy_s != '0);
          if (jump_s) begin
            jump_err_r <= 1'b1;
            pos_x_r    <= pt_x_r;
            pos_y_r    <= pt_y_r;
            state_r    <= S_IDLE;
          end else if ((dx_s == '0) && (dy_s == '0)) begin
            state_r <= S_IDLE;
          end else begin
            if (dx_s != '0) x_dir_r <= ~dx_s[DX_W-1];
            if (dy_s != '0) y_dir_r <= ~dy_s[DY_W-1];
            state_r <= S_DIR_SETUP;
          end
        end
        S_DIR_SETUP: begin
          // |delta| <= 1 here, so pos + delta is simply the point.
          x_step_r <= mv_x_r;
          y_step_r <= mv_y_r;
          pos_x_r  <= pt_x_r;
          pos_y_r  <= pt_y_r;
          cnt_r    <= PER_W'(1);
          state_r  <= S_HIGH;
        end
        S_HIGH: begin
          cnt_r <= cnt_r + PER_W'(1);
          if (cnt_r >= {1'b0, pw_r}) begin
            x_step_r <= 1'b0;
            y_step_r <= 1'b0;
            state_r  <= S_LOW;
          end
        end
        S_LOW: begin
          cnt_r <= cnt_r + PER_W'(1);
          if (cnt_r >= per_r) state_r <= S_IDLE;
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  assign bus.o_x_step        = x_step_r;
  assign bus.o_y_step        = y_step_r;
  assign bus.o_x_dir         = x_dir_r;
  assign bus.o_y_dir         = y_dir_r;
  assign bus.o_pos_x         = pos_x_r;
  assign bus.o_pos_y         = pos_y_r;
  assign bus.o_room_for_line = room_r;
  assign bus.o_busy          = !fifo_empty || (state_r != S_IDLE);
  assign bus.o_overflow      = overflow_r;
  assign bus.o_jump_err      = jump_err_r;
endmodule
